cic_decim_mc: RTL and testbench
===============================

# cic_decim_mc

Multi-channel, runtime-programmable CIC decimator. It is the next generation of the single-channel fixed-ratio CIC used behind the iCE40 sigma-delta modulators. It filters CHANNELS parallel low-width sigma-delta bitstreams through identical ORDER-stage integrator/comb chains, sharing one decimation counter. The decimation ratio is selectable at run time as 2^i_dec_bits. Outputs are normalised so DC gain is independent of ratio, and are qualified by a one-cycle valid strobe. It sits between the modulator front end and the sample FIFO/readout logic.

## Interface
- I_WIDTH, 2: signed two's-complement input sample width per channel.
- ORDER, 3: number of integrator and comb stages (differential delay 1).
- MAX_DEC_BITS, 8: largest supported log2 decimation ratio; sizes the accumulators.
- CHANNELS, 2: number of independent parallel channels.
- O_WIDTH, 16: signed output width per channel.
- i_clk  in  1  modulator-rate clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high; clears all state.
- i_en  in  1  clock enable; when low, every register holds.
- i_dec_bits  in  clog2(MAX_DEC_BITS+1)  requested log2 ratio D, legal 1..MAX_DEC_BITS.
- i_data  in  CHANNELS*I_WIDTH  packed inputs, channel 0 in LSBs.
- o_data  out  CHANNELS*O_WIDTH  packed decimated outputs, channel 0 in LSBs.
- o_valid  out  1  one-cycle strobe, o_data updated and valid.
- o_clk  out  1  decimated-rate square wave, for legacy consumers.

## Operation
- ACC_W = I_WIDTH + ORDER*MAX_DEC_BITS. All integrator and comb arithmetic is ACC_W bits, modular; wrap-around is required and must not be saturated.
- Integrators are registered: stage1 += x (sign-extended); stage k += previous stage's registered value.
- Decimation counter cnt runs 0..R-1 on enabled cycles, with R = 2^D_act. Decimation event: an enabled cycle with cnt == R-1.
- On each event, the last integrator register feeds the combinational comb chain. Each comb's delay register takes its stage input. The result is scaled and registered into o_data.
- Scaling: full-precision width F = I_WIDTH + ORDER*D_act; S = F − O_WIDTH.
  - S ≥ 0: arithmetic shift right by S (truncate toward −inf).
  - S < 0: shift left by −S.
  - DC gain for constant x is exactly x·2^(O_WIDTH−I_WIDTH).
- D_act reloads from i_dec_bits only on a decimation event, or on the first enabled cycle after reset. Illegal values (0 or >MAX_DEC_BITS) are clamped to 1 or MAX_DEC_BITS.
- Ratio change: when a reload changes D_act, the next ORDER decimation events update o_data but suppress o_valid, because comb delay lines hold stale-ratio samples. No accumulator is cleared.
- o_clk = 1 while cnt < R/2, else 0.
- Channels share cnt, D_act and the suppression counter. Channel datapaths are otherwise independent.

## Timing
- Reset values: o_data 0, o_valid 0, o_clk 0, cnt 0, all integrators/combs 0, suppression count 0. D_act is loaded on the first enabled cycle.
- o_valid rises the cycle after the event edge, lasts exactly one cycle, and coincides with the new o_data. Period is R enabled cycles.
- If i_en drops while o_valid is high, o_valid still falls on the next edge. Strobes are never stretched.
- Integrator pipeline latency from input to last integrator: ORDER cycles.
- Reset mid-period or mid-suppression: immediate return to reset state; no output is pending.
- i_en low: cnt, o_clk, accumulators and suppression count freeze. Events resume at the same phase.
- A ratio request arriving in the same cycle as an event takes effect for the following period.

## Structure
- Shared header cic_pkg: the clog2 function, ACC_W and F width functions, and the clamp function for D.
- Sub-module cic_decim_chan: one channel's integrators, combs and scaler. It takes the event strobe and D_act as inputs and is instantiated CHANNELS times by generate.
- Top level owns cnt, D_act, the suppression counter, o_valid and o_clk.

## Test plan
- Reset, then i_dec_bits=5 with constant ch0=1, ch1=−2. After settling, o_data ch0=16'h4000, ch1=16'h8000. o_valid fires every 32 cycles.
- i_dec_bits=1 with constant ch0=1. Output settles to 16'h4000 and o_valid fires every 2 cycles.
- Running at D=5, switch to D=3 mid-period. The change takes effect at the next event, the next 3 events carry no o_valid, then output is 16'h4000 every 8 cycles.
- Constant ch0=1 for 5000 cycles at D=8, so the integrators wrap. Every valid output stays 16'h4000.
- Toggle i_en low for 7 cycles mid-period. The o_valid spacing grows by exactly 7 clocks and data values are unchanged.
- Assert i_rst during suppression. All outputs are 0 immediately, and the first post-reset events are valid with no suppression.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared width and ratio helpers for the multi-channel CIC decimator.
package cic_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w(input int iw, input int order,
                               input int maxd);
    return iw + order * maxd;
  endfunction

  function automatic int f_w(input int iw, input int order,
                             input int d);
    return iw + order * d;
  endfunction

  function automatic int clamp_d(input int d, input int maxd);
    if (d < 1) return 1;
    if (d > maxd) return maxd;
    return d;
  endfunction

endpackage

// File: rtl/cic_decim_chan.sv
// One CIC channel: registered integrators, event-driven comb chain
// and ratio-dependent output scaler.
module cic_decim_chan
  import cic_pkg::*;
#(
  parameter int I_WIDTH = 2,
  parameter int ORDER = 3,
  parameter int MAX_DEC_BITS = 8,
  parameter int O_WIDTH = 16,
  parameter int DW = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_ev,
  input  logic [DW-1:0]      i_d,
  input  logic [I_WIDTH-1:0] i_x,
  output logic [O_WIDTH-1:0] o_y
);
  localparam int AW = acc_w(I_WIDTH, ORDER, MAX_DEC_BITS);

  logic [AW-1:0]      r_int [ORDER];
  logic [AW-1:0]      r_dly [ORDER];
  logic [O_WIDTH-1:0] r_y;
  logic [AW-1:0]      w_cin [ORDER];
  logic [AW-1:0]      w_v;
  logic [O_WIDTH-1:0] w_sc;
  int                 w_s;

  always_comb begin
    w_v = r_int[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      w_cin[k] = w_v;
      w_v = w_v - r_dly[k];
    end
    // Comb result fits in F bits, so modular AW-bit shifting is exact
    w_s = f_w(I_WIDTH, ORDER, int'(i_d)) - O_WIDTH;
    if (w_s >= 0)
      w_sc = O_WIDTH'($signed(w_v) >>> w_s);
    else
      w_sc = O_WIDTH'(w_v << (-w_s));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < ORDER; k++) begin
        r_int[k] <= '0;
        r_dly[k] <= '0;
      end
      r_y <= '0;
    end else if (i_en) begin
      r_int[0] <= r_int[0] + AW'($signed(i_x));
      for (int k = 1; k < ORDER; k++)
        r_int[k] <= r_int[k] + r_int[k-1];
      if (i_ev) begin
        for (int k = 0; k < ORDER; k++)
          r_dly[k] <= w_cin[k];
        r_y <= w_sc;
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel runtime-ratio CIC decimator: shared counter, ratio
// register, post-change valid suppression and legacy decimated clock.
module cic_decim_mc
  import cic_pkg::*;
#(
  parameter int I_WIDTH = 2,
  parameter int ORDER = 3,
  parameter int MAX_DEC_BITS = 8,
  parameter int CHANNELS = 2,
  parameter int O_WIDTH = 16,
  localparam int DW = clog2(MAX_DEC_BITS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic [DW-1:0]               i_dec_bits,
  input  logic [CHANNELS*I_WIDTH-1:0] i_data,
  output logic [CHANNELS*O_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_clk
);
  localparam int CW = MAX_DEC_BITS;
  localparam int SW = clog2(ORDER + 1);

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dact;
  logic          r_loaded;
  logic [SW-1:0] r_sup;
  logic          r_valid;
  logic          r_clk;

  logic [DW-1:0] w_dreq;
  logic [DW-1:0] w_dcur;
  logic [DW-1:0] w_dnext;
  logic [CW-1:0] w_last;
  logic [CW-1:0] w_half;
  logic [CW-1:0] w_cnt_nx;
  logic          w_ev;

  always_comb begin
    w_dreq = DW'(clamp_d(int'(i_dec_bits), MAX_DEC_BITS));
    // Before the first enabled cycle the ratio comes straight from the port
    w_dcur = r_loaded ? r_dact : w_dreq;
    w_last = CW'((1 << w_dcur) - 1);
    w_ev = i_en && (r_cnt == w_last);
    w_dnext = w_ev ? w_dreq : w_dcur;
    w_half = CW'(1 << (w_dnext - 1'b1));
    w_cnt_nx = w_ev ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_dact <= '0;
      r_loaded <= 1'b0;
      r_sup <= '0;
      r_valid <= 1'b0;
      r_clk <= 1'b0;
    end else begin
      r_valid <= w_ev && (r_sup == '0);
      if (i_en) begin
        r_loaded <= 1'b1;
        r_dact <= w_dnext;
        r_cnt <= w_cnt_nx;
        r_clk <= (w_cnt_nx < w_half);
        if (w_ev) begin
          if (w_dreq != w_dcur)
            r_sup <= SW'(ORDER);
          else if (r_sup != '0)
            r_sup <= r_sup - 1'b1;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_clk = r_clk;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    cic_decim_chan #(
      .I_WIDTH(I_WIDTH),
      .ORDER(ORDER),
      .MAX_DEC_BITS(MAX_DEC_BITS),
      .O_WIDTH(O_WIDTH),
      .DW(DW)
    ) u_chan (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_en(i_en),
      .i_ev(w_ev),
      .i_d(w_dcur),
      .i_x(i_data[c*I_WIDTH +: I_WIDTH]),
      .o_y(o_data[c*O_WIDTH +: O_WIDTH])
    );
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Directed bench for cic_decim_mc with hand-computed expectations.
module tb_cic_decim_mc;
  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  dec;
  logic [3:0]  din;
  logic [31:0] dout;
  logic        vld;
  logic        oclk;

  int total;
  int bad;
  int n;

  localparam logic [31:0] STEADY = 32'h8000_4000;

  cic_decim_mc dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_dec_bits(dec),
    .i_data(din),
    .o_data(dout),
    .o_valid(vld),
    .o_clk(oclk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!vld && cnt < maxc);
    if (!vld) begin
      total++;
      bad++;
      $error("FAIL timeout got=%0d exp<=%0d", cnt, maxc);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b0;
    dec = 4'd5;
    din = 4'b10_01;
    repeat (3) @(negedge clk);
    check("rst_data", dout, 32'h0);
    check("rst_valid", 32'(vld), 32'h0);
    check("rst_clk", 32'(oclk), 32'h0);

    // D=5, ch0=1, ch1=-2
    rst = 1'b0;
    en = 1'b1;
    wait_valid(40, n);
    check("d5_first", n, 32);
    repeat (5) wait_valid(40, n);
    wait_valid(40, n);
    check("d5_gap", n, 32);
    check("d5_data", dout, STEADY);
    check("d5_oclk_hi", 32'(oclk), 32'h1);
    repeat (16) @(negedge clk);
    check("d5_oclk_lo", 32'(oclk), 32'h0);
    wait_valid(40, n);
    check("d5_gap2", n, 16);

    // Switch to D=3 mid-period
    repeat (10) @(negedge clk);
    dec = 4'd3;
    wait_valid(40, n);
    check("d3_old_ev", n, 22);
    wait_valid(80, n);
    check("d3_supp", n, 32);
    check("d3_data", dout, STEADY);
    wait_valid(20, n);
    check("d3_gap", n, 8);
    check("d3_data2", dout, STEADY);

    // Switch to D=1
    dec = 4'd1;
    wait_valid(20, n);
    check("d1_old_ev", n, 8);
    wait_valid(20, n);
    check("d1_supp", n, 8);
    wait_valid(10, n);
    check("d1_gap", n, 2);
    check("d1_data", dout, STEADY);
    check("d1_oclk_hi", 32'(oclk), 32'h1);
    @(negedge clk);
    check("d1_oclk_lo", 32'(oclk), 32'h0);
    check("d1_strobe", 32'(vld), 32'h0);

    // Back to D=3, then enable gap
    dec = 4'd3;
    wait_valid(10, n);
    check("d3b_old_ev", n, 1);
    wait_valid(80, n);
    check("d3b_supp", n, 32);
    wait_valid(20, n);
    check("d3b_gap", n, 8);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_vld", 32'(vld), 32'h0);
    repeat (6) @(negedge clk);
    en = 1'b1;
    wait_valid(40, n);
    check("en_gap", n, 8);
    check("en_data", dout, STEADY);

    // D=8 long run, integrators wrap
    dec = 4'd8;
    wait_valid(20, n);
    check("d8_old_ev", n, 8);
    wait_valid(1100, n);
    check("d8_supp", n, 1024);
    for (int i = 0; i < 16; i++) begin
      wait_valid(300, n);
      check("d8_gap", n, 256);
      check("d8_data", dout, STEADY);
    end

    // Reset during suppression
    dec = 4'd2;
    wait_valid(300, n);
    check("d2_old_ev", n, 256);
    repeat (5) @(negedge clk);
    check("pre_rst_clk", 32'(oclk), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_data", dout, 32'h0);
    check("mid_rst_valid", 32'(vld), 32'h0);
    check("mid_rst_clk", 32'(oclk), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid(10, n);
    check("post_rst_first", n, 4);
    wait_valid(10, n);
    check("post_rst_gap", n, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
